counter_share_arbiter: RTL

- Shares one free-running-style up-counter between NREQ requesters. Each requester asks for a timed window of a programmable length.
- A round-robin arbiter picks one owner. The owner gets an exclusive grant while the counter runs 0..limit, then the controller signals completion.
- Sits between requesting blocks and the counter datapath. The count is exported so the owner can drive uo_out-style outputs from it.

---
 rtl/counter_share_arbiter_if.sv | 25 ++
 rtl/counter_share_arbiter.sv | 101 ++++++++++
 2 files changed

// File: rtl/counter_share_arbiter_if.sv
// Request/grant bundle between the requesting blocks and the shared-counter arbiter.
interface counter_share_arbiter_if #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDXW  = 2
);
    logic [NREQ-1:0]       req;
    logic [NREQ*WIDTH-1:0] len;
    logic [NREQ-1:0]       gnt;
    logic [IDXW-1:0]       owner;
    logic                  busy;
    logic [WIDTH-1:0]      count;
    logic                  done;
    logic                  abort;

    modport master (
        output req, len,
        input  gnt, owner, busy, count, done, abort
    );

    modport slave (
        input  req, len,
        output gnt, owner, busy, count, done, abort
    );
endinterface

// File: rtl/counter_share_arbiter.sv
// Round-robin owner selection for one shared up-counter; the owner holds an
// exclusive grant while the counter runs 0..limit.
module counter_share_arbiter #(
    parameter int NREQ  = 4,
    parameter int WIDTH = 8,
    parameter int IDXW  = 2
) (
    input logic clk,
    input logic rst,
    counter_share_arbiter_if.slave bus
);
    localparam int unsigned N = NREQ;

    typedef enum logic {IDLE, RUN} state_t;

    state_t            state;
    logic [IDXW-1:0]   last;
    logic [IDXW-1:0]   owner;
    logic [WIDTH-1:0]  limit;
    logic [WIDTH-1:0]  count;
    logic [NREQ-1:0]   gnt;
    logic              busy;
    logic              done;
    logic              abort;

    logic              found;
    logic [IDXW-1:0]   winner;
    int unsigned       idx;

    // Search starts just after the previous owner so every requester gets a turn.
    always_comb begin
        found  = 1'b0;
        winner = '0;
        idx    = 0;
        for (int unsigned k = 1; k <= N; k++) begin
            idx = (32'(last) + k) % N;
            if (!found && bus.req[idx]) begin
                found  = 1'b1;
                winner = IDXW'(idx);
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state <= IDLE;
            last  <= IDXW'(NREQ - 1);
            owner <= '0;
            limit <= '0;
            count <= '0;
            gnt   <= '0;
            busy  <= 1'b0;
            done  <= 1'b0;
            abort <= 1'b0;
        end else begin
            done  <= 1'b0;
            abort <= 1'b0;
            case (state)
                IDLE: begin
                    count <= '0;
                    gnt   <= '0;
                    // done/abort high means we only just left RUN: enforce one idle cycle.
                    if (found && !done && !abort) begin
                        owner       <= winner;
                        last        <= winner;
                        limit       <= bus.len[int'(winner)*WIDTH +: WIDTH];
                        gnt         <= '0;
                        gnt[winner] <= 1'b1;
                        busy        <= 1'b1;
                        state       <= RUN;
                    end
                end
                RUN: begin
                    if (!bus.req[owner]) begin
                        state <= IDLE;
                        gnt   <= '0;
                        busy  <= 1'b0;
                        count <= '0;
                        abort <= 1'b1;
                    end else if (count == limit) begin
                        state <= IDLE;
                        gnt   <= '0;
                        busy  <= 1'b0;
                        count <= '0;
                        done  <= 1'b1;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.gnt   = gnt;
    assign bus.owner = owner;
    assign bus.busy  = busy;
    assign bus.count = count;
    assign bus.done  = done;
    assign bus.abort = abort;
endmodule
